// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the unified memory port arbiter: FSM state codes,
// port-owner codes and the common ZERO constant.
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    // Access sequencer states
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_WAIT   = 2'd2,
        ARB_RESP   = 2'd3
    } arb_state_t;

    // Which requester currently owns the memory port
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_t;

    localparam logic ZERO = 1'b0;

endpackage : mem_port_arbiter_pkg

// File: rtl/mem_port_arbiter_lat_counter.sv
// ---------------------------------------------------------------------------
// arb_lat_counter
// Loadable down-counter that times the WAIT phase of a memory access.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   load : load LOAD_VAL (asserted on the cycle leaving ACCESS)
//   en   : count down (asserted while in WAIT)
//   done : high during the last counting cycle (count == 1 while enabled)
// ---------------------------------------------------------------------------
module arb_lat_counter #(
    parameter int LOAD_VAL = 1,
    parameter int CNT_W    = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_VAL);

    logic [CNT_W-1:0] cnt_r;

    // Remaining WAIT cycles; parks at zero once exhausted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= CNT_ZERO;
        end else if (load) begin
            cnt_r <= CNT_LOAD;
        end else if (en && (cnt_r != CNT_ZERO)) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign done = en & (cnt_r == CNT_ONE);

endmodule : arb_lat_counter

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported, fixed-latency memory between instruction fetch
// (IF) and load/store (DM). Each access runs IDLE -> ACCESS -> WAIT(MEM_LAT)
// -> RESP; read data is registered and completion is a one-cycle valid.
// Ports:
//   clk, rst                 clock / async active-low reset
//   if_req/if_addr/if_kill   fetch request, address, flush
//   if_rdata/if_valid        fetched word (registered) and completion pulse
//   if_stall                 if_req & ~if_valid
//   dm_req/dm_we/dm_addr/dm_wdata/dm_be   data request and command
//   dm_rdata/dm_valid        load data (registered) and completion pulse
//   dm_stall                 dm_req & ~dm_valid
//   mem_en/mem_we/mem_addr/mem_wdata/mem_be   registered memory command
//   mem_rdata                memory read data, valid MEM_LAT cycles after mem_en
//   busy                     sequencer not idle
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int MAX_STREAK = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_kill,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    output logic                if_stall,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_valid,
    output logic                dm_stall,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int BE_W     = DATA_W / 8;
    localparam int LAT_W    = $clog2(MEM_LAT + 1);
    localparam int STREAK_W = $clog2(MAX_STREAK + 1);

    localparam logic [STREAK_W-1:0] STREAK_ZERO = {STREAK_W{1'b0}};
    localparam logic [STREAK_W-1:0] STREAK_ONE  = STREAK_W'(32'd1);
    localparam logic [STREAK_W-1:0] STREAK_MAX  = STREAK_W'(MAX_STREAK);

    arb_state_t           state_r;
    arb_owner_t           owner_r;
    logic                 acc_we_r;
    logic                 mem_en_r;
    logic                 mem_we_r;
    logic [ADDR_W-1:0]    mem_addr_r;
    logic [DATA_W-1:0]    mem_wdata_r;
    logic [BE_W-1:0]      mem_be_r;
    logic [DATA_W-1:0]    if_rdata_r;
    logic [DATA_W-1:0]    dm_rdata_r;
    logic                 if_vld_r;
    logic                 dm_vld_r;
    logic [STREAK_W-1:0]  streak_r;
    logic                 drop_r;

    logic                 grant_if_s;
    logic                 grant_dm_s;
    logic [STREAK_W-1:0]  streak_dm_s;
    logic                 kill_hit_s;
    logic                 lat_load_s;
    logic                 lat_en_s;
    logic                 lat_done_s;

    // A flush only matters while the fetch actually owns the port.
    assign kill_hit_s = if_kill & (owner_r == OWN_IF) & (state_r != ARB_IDLE);
    assign lat_load_s = (state_r == ARB_ACCESS);
    assign lat_en_s   = (state_r == ARB_WAIT);

    arb_lat_counter #(
        .LOAD_VAL (MEM_LAT),
        .CNT_W    (LAT_W)
    ) u_lat (
        .clk  (clk),
        .rst  (rst),
        .load (lat_load_s),
        .en   (lat_en_s),
        .done (lat_done_s)
    );

    // Owner selection: data side wins contention until its streak limit.
    always_comb begin
        grant_if_s = 1'b0;
        grant_dm_s = 1'b0;
        if (dm_req && if_req) begin
            if (streak_r < STREAK_MAX) begin
                grant_dm_s = 1'b1;
            end else begin
                grant_if_s = 1'b1;
            end
        end else if (dm_req) begin
            grant_dm_s = 1'b1;
        end else if (if_req) begin
            grant_if_s = 1'b1;
        end else begin
            grant_if_s = 1'b0;
            grant_dm_s = 1'b0;
        end
    end

    // Streak value after a data grant: counts only while a fetch is waiting.
    always_comb begin
        streak_dm_s = STREAK_ZERO;
        if (!if_req) begin
            streak_dm_s = STREAK_ZERO;
        end else if (streak_r == STREAK_MAX) begin
            streak_dm_s = streak_r;
        end else begin
            streak_dm_s = streak_r + STREAK_ONE;
        end
    end

    // Access sequencer with all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ARB_IDLE;
            owner_r     <= OWN_IF;
            acc_we_r    <= ZERO;
            mem_en_r    <= ZERO;
            mem_we_r    <= ZERO;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            mem_be_r    <= {BE_W{1'b0}};
            if_rdata_r  <= {DATA_W{1'b0}};
            dm_rdata_r  <= {DATA_W{1'b0}};
            if_vld_r    <= ZERO;
            dm_vld_r    <= ZERO;
            streak_r    <= STREAK_ZERO;
            drop_r      <= ZERO;
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    if_vld_r <= ZERO;
                    dm_vld_r <= ZERO;
                    drop_r   <= ZERO;
                    if (grant_dm_s) begin
                        state_r     <= ARB_ACCESS;
                        owner_r     <= OWN_DM;
                        acc_we_r    <= dm_we;
                        mem_en_r    <= 1'b1;
                        mem_we_r    <= dm_we;
                        mem_addr_r  <= dm_addr;
                        mem_wdata_r <= dm_wdata;
                        mem_be_r    <= dm_be;
                        streak_r    <= streak_dm_s;
                    end else if (grant_if_s) begin
                        state_r     <= ARB_ACCESS;
                        owner_r     <= OWN_IF;
                        acc_we_r    <= ZERO;
                        mem_en_r    <= 1'b1;
                        mem_we_r    <= ZERO;
                        mem_addr_r  <= if_addr;
                        mem_wdata_r <= {DATA_W{1'b0}};
                        mem_be_r    <= {BE_W{1'b1}};
                        streak_r    <= STREAK_ZERO;
                    end else begin
                        state_r     <= ARB_IDLE;
                        mem_en_r    <= ZERO;
                        mem_we_r    <= ZERO;
                        mem_addr_r  <= {ADDR_W{1'b0}};
                        mem_wdata_r <= {DATA_W{1'b0}};
                        mem_be_r    <= {BE_W{1'b0}};
                    end
                end
                ARB_ACCESS: begin
                    // Command is on the bus for exactly this one cycle.
                    state_r     <= ARB_WAIT;
                    mem_en_r    <= ZERO;
                    mem_we_r    <= ZERO;
                    mem_addr_r  <= {ADDR_W{1'b0}};
                    mem_wdata_r <= {DATA_W{1'b0}};
                    mem_be_r    <= {BE_W{1'b0}};
                    if (kill_hit_s) begin
                        drop_r <= 1'b1;
                    end else begin
                        drop_r <= drop_r;
                    end
                end
                ARB_WAIT: begin
                    if (kill_hit_s) begin
                        drop_r <= 1'b1;
                    end else begin
                        drop_r <= drop_r;
                    end
                    if (lat_done_s) begin
                        state_r <= ARB_RESP;
                        if (owner_r == OWN_IF) begin
                            // Data still lands when flushed; only the pulse is suppressed.
                            if_rdata_r <= mem_rdata;
                            if_vld_r   <= ~(drop_r | if_kill);
                        end else begin
                            if (!acc_we_r) begin
                                dm_rdata_r <= mem_rdata;
                            end else begin
                                dm_rdata_r <= dm_rdata_r;
                            end
                            dm_vld_r <= 1'b1;
                        end
                    end else begin
                        state_r <= ARB_WAIT;
                    end
                end
                ARB_RESP: begin
                    state_r  <= ARB_IDLE;
                    if_vld_r <= ZERO;
                    dm_vld_r <= ZERO;
                    drop_r   <= ZERO;
                end
                default: begin
                    state_r     <= ARB_IDLE;
                    mem_en_r    <= ZERO;
                    mem_we_r    <= ZERO;
                    mem_addr_r  <= {ADDR_W{1'b0}};
                    mem_wdata_r <= {DATA_W{1'b0}};
                    mem_be_r    <= {BE_W{1'b0}};
                    if_vld_r    <= ZERO;
                    dm_vld_r    <= ZERO;
                    drop_r      <= ZERO;
                end
            endcase
        end
    end

    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_be    = mem_be_r;
    assign if_rdata  = if_rdata_r;
    assign dm_rdata  = dm_rdata_r;
    // A flush arriving in the RESP cycle itself still cancels the pulse.
    assign if_valid  = if_vld_r & ~if_kill;
    assign dm_valid  = dm_vld_r;
    assign if_stall  = if_req & ~if_valid;
    assign dm_stall  = dm_req & ~dm_valid;
    assign busy      = (state_r != ARB_IDLE);

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Three arbiter instances (MEM_LAT = 1, 3, 4; MAX_STREAK = 2) share one set
// of request inputs; each has its own fixed-latency memory model. Expected
// completions are queued when a request is issued and popped when a valid
// pulse appears.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic rst;
    logic        if_req, if_kill, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [3:0]  dm_be;

    logic [NDUT-1:0][31:0] if_rdata_a, dm_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
    logic [NDUT-1:0][3:0]  mem_be_a;
    logic [NDUT-1:0]       if_valid_a, if_stall_a, dm_valid_a, dm_stall_a;
    logic [NDUT-1:0]       mem_en_a, mem_we_a, busy_a;

    int cyc = 0;
    int c0 = 0;
    int total = 0;
    int bad = 0;

    typedef struct {
        logic        port;   // 0 = IF, 1 = DM
        logic [31:0] data;
        int          cycle;  // completion cycle relative to request cycle 0
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'h00A0_0093;
        else return a ^ 32'h5A5A_0000;
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
        logic [31:0] pd [4];
        bit          pv [4];

        mem_port_arbiter #(
            .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .MAX_STREAK(2)
        ) u_dut (
            .clk(clk), .rst(rst),
            .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
            .if_rdata(if_rdata_a[g]), .if_valid(if_valid_a[g]), .if_stall(if_stall_a[g]),
            .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
            .dm_rdata(dm_rdata_a[g]), .dm_valid(dm_valid_a[g]), .dm_stall(dm_stall_a[g]),
            .mem_en(mem_en_a[g]), .mem_we(mem_we_a[g]), .mem_addr(mem_addr_a[g]),
            .mem_wdata(mem_wdata_a[g]), .mem_be(mem_be_a[g]), .mem_rdata(mem_rdata_a[g]),
            .busy(busy_a[g])
        );

        // Memory model: read data appears exactly LAT cycles after the enable cycle, garbage otherwise.
        always @(posedge clk) begin
            pv[0] <= mem_en_a[g] & ~mem_we_a[g];
            pd[0] <= rd_fn(mem_addr_a[g]);
            for (int k = 1; k < 4; k++) begin
                pv[k] <= pv[k-1];
                pd[k] <= pd[k-1];
            end
        end
        assign mem_rdata_a[g] = pv[LAT-1] ? pd[LAT-1] : 32'hBAD0_BAD0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic at_start(input int k);
        while (cyc - c0 < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic at_sample(input int k);
        at_start(k);
        @(negedge clk);
    endtask

    task automatic begin_txn();
        @(posedge clk);
        #1;
        c0 = cyc;
    endtask

    task automatic sb_push(input logic port, input logic [31:0] data, input int cycle);
        exp_t e;
        e.port = port;
        e.data = data;
        e.cycle = cycle;
        sb.push_back(e);
    endtask

    task automatic sb_check(input int g);
        exp_t e;
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_onehot", 32'(if_valid_a[g] ^ dm_valid_a[g]), 32'd1);
            chk("sb_port", 32'(dm_valid_a[g]), 32'(e.port));
            chk("sb_data", e.port ? dm_rdata_a[g] : if_rdata_a[g], e.data);
            chk("sb_cycle", 32'(cyc - c0), 32'(e.cycle));
        end
    endtask

    task automatic wait_valid(input int g, input int budget);
        int  n;
        logic seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            if (if_valid_a[g] || dm_valid_a[g]) seen = 1'b1;
        end
        chk("valid_seen", 32'(seen), 32'd1);
        if (seen) sb_check(g);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        if_req = 1'b0; if_kill = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic pat_port [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int   exp_streak [6] = '{1, 2, 0, 1, 2, 0};

        rst = 1'b0;
        if_req = 1'b0; if_kill = 1'b0; if_addr = 32'h0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0; dm_be = 4'h0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_en",   32'(mem_en_a[0]), 32'd0);
        chk("rst_mem_we",   32'(mem_we_a[0]), 32'd0);
        chk("rst_mem_addr", mem_addr_a[0], 32'd0);
        chk("rst_mem_wdat", mem_wdata_a[0], 32'd0);
        chk("rst_mem_be",   32'(mem_be_a[0]), 32'd0);
        chk("rst_if_rdata", if_rdata_a[0], 32'd0);
        chk("rst_dm_rdata", dm_rdata_a[0], 32'd0);
        chk("rst_if_valid", 32'(if_valid_a[0]), 32'd0);
        chk("rst_dm_valid", 32'(dm_valid_a[0]), 32'd0);
        chk("rst_busy",     32'(busy_a[0]), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Fetch only, MEM_LAT=1
        begin_txn();
        if_req = 1'b1; if_addr = 32'h10;
        sb_push(1'b0, 32'h00A0_0093, 3);
        at_sample(0);
        chk("f_stall0", 32'(if_stall_a[0]), 32'd1);
        chk("f_busy0",  32'(busy_a[0]), 32'd0);
        at_sample(1);
        chk("f_mem_en1",   32'(mem_en_a[0]), 32'd1);
        chk("f_mem_we1",   32'(mem_we_a[0]), 32'd0);
        chk("f_mem_addr1", mem_addr_a[0], 32'h10);
        chk("f_stall1",    32'(if_stall_a[0]), 32'd1);
        chk("f_busy1",     32'(busy_a[0]), 32'd1);
        at_sample(2);
        chk("f_mem_en2", 32'(mem_en_a[0]), 32'd0);
        chk("f_stall2",  32'(if_stall_a[0]), 32'd1);
        wait_valid(0, 4);
        chk("f_stall3", 32'(if_stall_a[0]), 32'd0);
        if_req = 1'b0;
        at_sample(4);
        chk("f_busy4",  32'(busy_a[0]), 32'd0);
        chk("f_valid4", 32'(if_valid_a[0]), 32'd0);

        // Load then store, MEM_LAT=1
        begin_txn();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
        sb_push(1'b1, 32'h5A5A_0040, 3);
        at_sample(0);
        chk("l_stall0", 32'(dm_stall_a[0]), 32'd1);
        wait_valid(0, 5);
        dm_req = 1'b0;
        begin_txn();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'hF;
        sb_push(1'b1, 32'h5A5A_0040, 3);
        at_start(1);
        dm_addr = 32'h200; dm_wdata = 32'h1234_5678; dm_be = 4'h0;
        at_sample(1);
        chk("s_mem_en",    32'(mem_en_a[0]), 32'd1);
        chk("s_mem_we",    32'(mem_we_a[0]), 32'd1);
        chk("s_mem_addr",  mem_addr_a[0], 32'h100);
        chk("s_mem_wdata", mem_wdata_a[0], 32'hDEAD_BEEF);
        chk("s_mem_be",    32'(mem_be_a[0]), 32'hF);
        wait_valid(0, 4);
        dm_req = 1'b0; dm_we = 1'b0;

        // Contention with starvation guard, MAX_STREAK=2
        begin_txn();
        if_req = 1'b1; if_addr = 32'h10;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
        for (int i = 0; i < 6; i++) begin
            sb_push(pat_port[i], pat_port[i] ? 32'h5A5A_0040 : 32'h00A0_0093, 4 * i + 3);
        end
        for (int i = 0; i < 6; i++) begin
            at_sample(4 * i + 1);
            chk("c_grant_addr", mem_addr_a[0], pat_port[i] ? 32'h40 : 32'h10);
            chk("c_streak", 32'(g_dut[0].u_dut.streak_r), 32'(exp_streak[i]));
            wait_valid(0, 4);
        end
        if_req = 1'b0; dm_req = 1'b0;

        // Kill during WAIT, MEM_LAT=3
        do_reset();
        begin_txn();
        if_req = 1'b1; if_addr = 32'h20;
        at_sample(1);
        chk("k_mem_en1",   32'(mem_en_a[1]), 32'd1);
        chk("k_mem_addr1", mem_addr_a[1], 32'h20);
        at_start(2);
        if_kill = 1'b1;
        at_start(3);
        if_kill = 1'b0; if_req = 1'b0;
        at_sample(5);
        chk("k_no_valid5", 32'(if_valid_a[1]), 32'd0);
        chk("k_busy5",     32'(busy_a[1]), 32'd1);
        chk("k_rdata5",    if_rdata_a[1], 32'h5A5A_0020);
        at_sample(6);
        chk("k_idle6", 32'(busy_a[1]), 32'd0);
        begin_txn();
        if_req = 1'b1; if_addr = 32'h10;
        sb_push(1'b0, 32'h00A0_0093, 5);
        wait_valid(1, 8);
        if_req = 1'b0;

        // Latency sweep, MEM_LAT=4
        do_reset();
        begin_txn();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
        sb_push(1'b1, 32'h5A5A_0080, 6);
        for (int k = 0; k < 8; k++) begin
            at_sample(k);
            chk("lat_busy", 32'(busy_a[2]), 32'((k >= 1) && (k <= 6)));
            if (k == 5) begin
                chk("lat_rdata5", dm_rdata_a[2], 32'd0);
                chk("lat_valid5", 32'(dm_valid_a[2]), 32'd0);
            end
            if (k == 6) begin
                sb_check(2);
                dm_req = 1'b0;
            end
        end

        // Reset mid-access: MEM_LAT=4 in WAIT, MEM_LAT=1 in RESP
        do_reset();
        begin_txn();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h44;
        at_sample(3);
        chk("r_pre_valid0", 32'(dm_valid_a[0]), 32'd1);
        chk("r_pre_rdata0", dm_rdata_a[0], 32'h5A5A_0044);
        chk("r_pre_busy2",  32'(busy_a[2]), 32'd1);
        rst = 1'b0;
        #1;
        chk("r_valid0", 32'(dm_valid_a[0]), 32'd0);
        chk("r_rdata0", dm_rdata_a[0], 32'd0);
        chk("r_busy0",  32'(busy_a[0]), 32'd0);
        chk("r_busy2",  32'(busy_a[2]), 32'd0);
        chk("r_mem_en2", 32'(mem_en_a[2]), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        c0 = cyc;
        sb_push(1'b1, 32'h5A5A_0044, 6);
        at_sample(0);
        chk("r_idle0", 32'(busy_a[2]), 32'd0);
        at_sample(1);
        chk("r_mem_en1",   32'(mem_en_a[2]), 32'd1);
        chk("r_mem_addr1", mem_addr_a[2], 32'h44);
        wait_valid(2, 8);
        dm_req = 1'b0;

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_port_arbiter

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Multicycle controller that shares one single-ported, fixed-latency unified memory between the IF stage (instruction fetch) and the MEM stage (load/store).
- Arbitrates between the two, sequences each access through ACCESS/WAIT/RESP, and returns registered read data with a one-cycle valid pulse.
- Drives per-requester stall signals that the pipeline uses to freeze its stage registers; sits between the pipeline stages and the memory macro.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; byte enables are DATA_W/8 bits
MEM_LAT, 1, memory read latency in cycles after the enable cycle; legal values >= 1
MAX_STREAK, 2, maximum consecutive data grants while IF is waiting; legal values >= 1

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
if_req  in  1  fetch request; held until if_valid or if_kill
if_addr  in  ADDR_W  fetch address
if_kill  in  1  pipeline flush: discard in-flight fetch result
if_rdata  out  DATA_W  fetched instruction (registered)
if_valid  out  1  one-cycle fetch completion pulse
if_stall  out  1  if_req & ~if_valid (combinational)
dm_req  in  1  data request; held until dm_valid
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_be  in  DATA_W/8  store byte enables
dm_rdata  out  DATA_W  load data (registered)
dm_valid  out  1  one-cycle completion pulse (loads and stores)
dm_stall  out  1  dm_req & ~dm_valid (combinational)
mem_en, mem_we  out  1 each  memory command strobes (registered)
mem_addr  out  ADDR_W  memory address (registered)
mem_wdata  out  DATA_W  memory write data (registered)
mem_be  out  DATA_W/8  memory byte enables (registered)
mem_rdata  in  DATA_W  valid MEM_LAT cycles after the mem_en cycle
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all mem_* = 0; if_rdata = dm_rdata = 0; valids = 0; streak = 0; drop = 0. Reset mid-access abandons the access with no valid pulse.
- States and cycle numbering (request sampled in IDLE at cycle 0):
  - IDLE (cycle 0): sample requests and pick an owner.
  - ACCESS (cycle 1): mem_en = 1 and the owner's command is driven for exactly one cycle.
  - WAIT (cycles 2 .. MEM_LAT+1): lasts MEM_LAT cycles; all mem_* outputs = 0. On the last WAIT edge, mem_rdata is captured into the owner's rdata register (loads and fetches only).
  - RESP (cycle MEM_LAT+2): owner's valid = 1. Requests are ignored in RESP. Next state is IDLE.
- Timing: request-to-valid latency is MEM_LAT+2 cycles; back-to-back period is MEM_LAT+3 cycles.
- Stores: dm_rdata is unchanged; dm_valid still pulses in RESP.
- Arbitration in IDLE:
  - Only one requester: it wins.
  - Both requesting: dm wins if streak < MAX_STREAK, otherwise IF wins.
- Streak counter:
  - Increments on a dm grant while if_req = 1, saturating at MAX_STREAK.
  - Clears on any IF grant, and on a dm grant while if_req = 0.
- Kill:
  - if_kill = 1 in any cycle from ACCESS through RESP with IF as owner sets drop.
  - When drop is set, the memory access still completes and if_rdata still updates, but if_valid stays 0 in RESP.
  - drop clears on entry to IDLE.
  - if_kill in IDLE, or while dm owns the port, has no effect.
- Request contract: a requester dropping req mid-access (other than via if_kill) is a protocol violation; the access completes regardless.
- The owner's command fields are latched at grant; later input changes do not affect mem_*.
- MEM_LAT counter is sized $clog2(MEM_LAT+1) and loads MEM_LAT on ACCESS exit.

Decomposition:
- Shared defines file:
  - state encodings ARB_IDLE/ARB_ACCESS/ARB_WAIT/ARB_RESP (2 bits)
  - owner encodings OWN_IF/OWN_DM
  - existing ZERO constant
- One sub-module: arb_lat_counter, a loadable down-counter with a done flag, instantiated once for the WAIT duration.

Test Plan:
- Fetch only: MEM_LAT=1, if_req=1, if_addr=0x10 at cycle 0, mem_rdata=0x00A00093 in cycle 2 -> mem_en=1 with mem_addr=0x10 in cycle 1; if_valid=1 with if_rdata=0x00A00093 in cycle 3; if_stall=1 in cycles 0-2.
- Store: dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF, dm_be=0xF -> cycle 1 has mem_en=mem_we=1 with those values; dm_valid in cycle 3; dm_rdata unchanged.
- Contention and starvation guard: MAX_STREAK=2, if_req and dm_req both held high across repeated accesses -> grant order dm, dm, IF, dm, dm, IF; streak returns to 0 after each IF grant.
- Kill: IF granted at cycle 0, if_kill pulsed in cycle 2 (MEM_LAT=3) -> mem_en still pulses in cycle 1, no if_valid in cycle 5, state IDLE in cycle 6, next if_req serviced normally.
- Latency sweep: MEM_LAT=4 load -> mem_rdata is captured at the end of cycle 5, dm_valid in cycle 6, busy=1 for cycles 1-6.
- Reset mid-access: rst low during WAIT -> mem_* and valids go to 0 immediately; after release, state is IDLE and a pending dm_req is re-granted from cycle 0.
